// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin registered mux.
// Output-register state plus the select-width rule used by every file.
package rr_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Producer/consumer bundle around the arbiter.
// master = testbench/producers side, slave = arbiter side.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
);
  import rr_mux_pkg::*;

  localparam int SW = sel_width(N);

  logic [N-1:0]     in_valid;
  logic [WIDTH-1:0] in_data [N];
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SW-1:0]    out_sel;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/rr_mux_arbiter_picker.sv
// Rotating priority search: first requester after i_last_ptr wins.
// Purely combinational; one-hot grant plus its index.
module rr_priority_picker
  import rr_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = sel_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_last_ptr,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_grant_idx
);

  logic [SW-1:0] w_j;
  logic          w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_j         = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = SW'((int'(i_last_ptr) + k) % N);
      if (!w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_grant_idx  = w_j;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 round-robin registered mux with a one-entry output stage.
// RR_MUX_GRANT_CNT_EN adds saturating per-channel grant counters.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input logic               clock,
  input logic               reset_L,
  rr_mux_arbiter_if.slave   bus
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt [N]
`endif
);

  localparam int SW = sel_width(N);

  out_state_t       r_state;
  out_state_t       w_state_nxt;
  logic [SW-1:0]    r_last_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_sel;
  logic [N-1:0]     w_grant;
  logic [SW-1:0]    w_idx;
  logic             w_load;
  logic             w_accept;

  rr_priority_picker #(.N(N)) u_picker (
    .i_req       (bus.in_valid),
    .i_last_ptr  (r_last_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx)
  );

  assign w_load       = (r_state == EMPTY) | bus.out_ready;
  // Reset gating keeps producers from seeing a grant during reset.
  assign bus.in_ready = w_grant & {N{w_load & reset_L}};
  assign w_accept     = |bus.in_ready;

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_accept) w_state_nxt = FULL;
      FULL:  if (bus.out_ready) w_state_nxt = w_accept ? FULL : EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= EMPTY;
      r_last_ptr <= SW'(N - 1);
      r_data     <= '0;
      r_sel      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data     <= bus.in_data[w_idx];
        r_sel      <= w_idx;
        r_last_ptr <= w_idx;
      end
    end
  end

`ifdef RR_MUX_GRANT_CNT_EN
  logic [CNT_W-1:0] r_grant_cnt [N];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < N; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.in_ready[i] && r_grant_cnt[i] != '1)
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench: N=4 scenarios plus an N=2 scoreboard sweep.
// Define RR_MUX_GRANT_CNT_EN to also exercise the grant counters.
module tb_rr_mux_arbiter;

  logic clock;
  logic reset_L;
  int   n_chk;
  int   n_fail;

  rr_mux_arbiter_if #(.WIDTH(4), .N(4)) if4 ();
  rr_mux_arbiter_if #(.WIDTH(4), .N(2)) if2 ();

`ifdef RR_MUX_GRANT_CNT_EN
  logic [1:0] gc4 [4];
  logic [7:0] gc2 [2];
`endif

  rr_mux_arbiter #(
    .WIDTH(4), .N(4)
`ifdef RR_MUX_GRANT_CNT_EN
    , .CNT_W(2)
`endif
  ) u_dut4 (
    .clock     (clock),
    .reset_L   (reset_L),
    .bus       (if4)
`ifdef RR_MUX_GRANT_CNT_EN
    , .grant_cnt (gc4)
`endif
  );

  rr_mux_arbiter #(
    .WIDTH(4), .N(2)
`ifdef RR_MUX_GRANT_CNT_EN
    , .CNT_W(8)
`endif
  ) u_dut2 (
    .clock     (clock),
    .reset_L   (reset_L),
    .bus       (if2)
`ifdef RR_MUX_GRANT_CNT_EN
    , .grant_cnt (gc2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // sweep model state
  logic [1:0] pend;
  logic [3:0] pdata [2];
  logic [3:0] nd;
  logic [1:0] pat;
  logic       ordy;
  logic       load;
  logic [1:0] er;
  logic       ch;
  logic [4:0] w;
  logic [4:0] q [$];
  int         last2;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_L = 1'b0;
    if4.in_valid = 4'b0100;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) if4.in_data[i] = 4'h0;
    if4.in_data[2] = 4'hA;
    if2.in_valid = 2'b00;
    if2.out_ready = 1'b0;
    if2.in_data[0] = 4'h0;
    if2.in_data[1] = 4'h0;

    tick();
    tick();
    chk("rst_ovld", if4.out_valid, 1'b0);
    chk("rst_odata", if4.out_data, 4'h0);
    chk("rst_osel", if4.out_sel, 2'd0);
    chk("rst_irdy", if4.in_ready, 4'b0000);

    // single requester on ch2
    reset_L = 1'b1;
    #1;
    chk("single_rdy0", if4.in_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("single_ovld", if4.out_valid, 1'b1);
      chk("single_data", if4.out_data, 4'hA);
      chk("single_sel", if4.out_sel, 2'd2);
      chk("single_rdy", if4.in_ready, 4'b0100);
    end

    // asynchronous reset while FULL and requesting
    #2;
    reset_L = 1'b0;
    #1;
    chk("amid_ovld", if4.out_valid, 1'b0);
    chk("amid_odata", if4.out_data, 4'h0);
    chk("amid_irdy", if4.in_ready, 4'b0000);
    if4.in_valid = 4'b0000;
    tick();
    reset_L = 1'b1;

    // fairness: all four requesting
    if4.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) if4.in_data[i] = 4'(i + 1);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("fair_rdy", if4.in_ready, 32'(1 << (k % 4)));
      tick();
      chk("fair_sel", if4.out_sel, 32'(k % 4));
      chk("fair_data", if4.out_data, 32'(k % 4 + 1));
    end

    // backpressure with out_data = 5
    if4.in_valid = 4'b0100;
    if4.in_data[2] = 4'h5;
    #1;
    chk("bp_load_rdy", if4.in_ready, 4'b0100);
    tick();
    chk("bp_data0", if4.out_data, 4'h5);
    if4.out_ready = 1'b0;
    if4.in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", if4.in_ready, 4'b0000);
      chk("bp_data", if4.out_data, 4'h5);
      chk("bp_ovld", if4.out_valid, 1'b1);
      tick();
    end
    if4.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", if4.in_ready, 4'b1000);
    tick();
    chk("bp_rel_data", if4.out_data, 4'h4);
    chk("bp_rel_sel", if4.out_sel, 2'd3);

    // wrap and skip from last_ptr=3
    if4.in_valid = 4'b0110;
    if4.in_data[1] = 4'h6;
    if4.in_data[2] = 4'h7;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("wrap_rdy", if4.in_ready, (k == 1) ? 4'b0100 : 4'b0010);
      tick();
      chk("wrap_sel", if4.out_sel, (k == 1) ? 2'd2 : 2'd1);
      chk("wrap_data", if4.out_data, (k == 1) ? 4'h7 : 4'h6);
    end
    if4.in_valid = 4'b0000;
    tick();
    chk("drain_ovld", if4.out_valid, 1'b0);

    // N=2 sweep with an independent scoreboard
    pend  = 2'b00;
    nd    = 4'h0;
    last2 = 1;
    pdata[0] = 4'h0;
    pdata[1] = 4'h0;
    for (int c = 0; c < 320; c++) begin
      pat  = 2'(c) ^ 2'(c >> 4);
      ordy = c[2] ^ c[3] ^ c[6];
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && pat[j]) begin
          pend[j]  = 1'b1;
          pdata[j] = nd;
          nd       = nd + 4'h1;
        end
        if2.in_data[j] = pdata[j];
      end
      if2.in_valid  = pend;
      if2.out_ready = ordy;
      #1;
      load = (q.size() == 0) || ordy;
      er = 2'b00;
      if (load) begin
        if (pend == 2'b11) er = (last2 == 0) ? 2'b10 : 2'b01;
        else er = pend;
      end
      chk("sw_rdy", if2.in_ready, er);
      chk("sw_ovld", if2.out_valid, q.size() != 0);
      if (q.size() != 0 && ordy) begin
        w = q.pop_front();
        chk("sw_data", if2.out_data, w[3:0]);
        chk("sw_sel", if2.out_sel, w[4]);
      end
      if (er != 2'b00) begin
        ch = er[1];
        q.push_back({ch, pdata[ch]});
        pend[ch] = 1'b0;
        last2 = int'(ch);
      end
      tick();
    end
    if2.in_valid = 2'b00;

`ifdef RR_MUX_GRANT_CNT_EN
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
    if4.in_valid = 4'b0001;
    if4.in_data[0] = 4'h3;
    if4.out_ready = 1'b1;
    tick();
    tick();
    chk("cnt_two", gc4[0], 2'd2);
    for (int k = 0; k < 3; k++) tick();
    chk("cnt_sat", gc4[0], 2'd3);
    chk("cnt_ch1", gc4[1], 2'd0);
    chk("cnt_ch2", gc4[2], 2'd0);
    chk("cnt_ch3", gc4[3], 2'd0);
    if4.in_valid = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
